matrix_scan_receiver: RTL and testbench

MATRIX_SCAN_RECEIVER -- requirements
Module: matrix_scan_receiver

---
 rtl/matrix_scan_receiver_pkg.sv | 37 +++
 rtl/matrix_scan_sync_filter.sv | 93 +++++++++
 rtl/matrix_scan_receiver.sv | 176 +++++++++++++++++
 tb/tb_matrix_scan_receiver.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_scan_receiver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_scan_receiver_pkg                                              |
// | Shared dimensions, FSM encoding and column-vector helpers.            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package matrix_scan_receiver_pkg;

    localparam int NUM_COLS = 5;
    localparam int NUM_ROWS = 7;

    localparam logic [0:0] ST_HUNT    = 1'b0;
    localparam logic [0:0] ST_CAPTURE = 1'b1;

    function automatic logic [2:0] count_ones(input logic [NUM_COLS-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Only meaningful when the vector is one-hot.
    function automatic logic [2:0] col_index(input logic [NUM_COLS-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_scan_sync_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_scan_sync_filter                                               |
// | Synchronizes the scan pins and emits one accept pulse per stable      |
// | column dwell.                                                         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module matrix_scan_sync_filter
    import matrix_scan_receiver_pkg::*;
#(
    parameter int SETTLE         = 2,
    parameter bit COL_ACTIVE_LOW = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_COLS-1:0] i_col,
    input  logic [NUM_ROWS-1:0] i_row,
    output logic                o_accept,
    output logic [NUM_COLS-1:0] o_col,
    output logic [NUM_ROWS-1:0] o_row
);

    localparam logic [3:0] c_settle = 4'(SETTLE);

    logic [NUM_COLS-1:0] col_s1_q, col_s1_d, col_s2_q, col_s2_d;
    logic [NUM_ROWS-1:0] row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [NUM_COLS-1:0] prev_q, prev_d;
    logic [NUM_COLS-1:0] col_out_q, col_out_d;
    logic [NUM_ROWS-1:0] row_out_q, row_out_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [1:0]          warm_q, warm_d;
    logic                accept_q, accept_d;
    logic [NUM_COLS-1:0] w_col_norm;
    logic                w_changed;

    always_comb begin
        w_col_norm = COL_ACTIVE_LOW ? ~col_s2_q : col_s2_q;
        w_changed  = (w_col_norm != prev_q);
        col_s1_d   = i_col;
        col_s2_d   = col_s1_q;
        row_s1_d   = i_row;
        row_s2_d   = row_s1_q;
        prev_d     = w_col_norm;
        col_out_d  = w_col_norm;
        row_out_d  = row_s2_q;
        warm_d     = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
        cnt_d      = '0;
        accept_d   = 1'b0;
        // Hold off until the synchronizer holds real pin samples, not reset zeros.
        if (warm_q == 2'd2) begin
            if (w_changed) begin
                cnt_d = 4'd1;
            end else if (cnt_q < c_settle) begin
                cnt_d = cnt_q + 4'd1;
            end else begin
                cnt_d = cnt_q;
            end
            accept_d = (cnt_d == c_settle) && (w_changed || (cnt_q != c_settle));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_s1_q  <= '0;
            col_s2_q  <= '0;
            row_s1_q  <= '0;
            row_s2_q  <= '0;
            prev_q    <= '0;
            col_out_q <= '0;
            row_out_q <= '0;
            cnt_q     <= '0;
            warm_q    <= '0;
            accept_q  <= 1'b0;
        end else begin
            col_s1_q  <= col_s1_d;
            col_s2_q  <= col_s2_d;
            row_s1_q  <= row_s1_d;
            row_s2_q  <= row_s2_d;
            prev_q    <= prev_d;
            col_out_q <= col_out_d;
            row_out_q <= row_out_d;
            cnt_q     <= cnt_d;
            warm_q    <= warm_d;
            accept_q  <= accept_d;
        end
    end

    assign o_accept = accept_q;
    assign o_col    = col_out_q;
    assign o_row    = row_out_q;

endmodule
`default_nettype wire

// File: rtl/matrix_scan_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_scan_receiver                                                  |
// | Rebuilds a 5x7 image from a scanned matrix and flags scan violations. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module matrix_scan_receiver
    import matrix_scan_receiver_pkg::*;
#(
    parameter int SETTLE         = 2,
    parameter int TIMEOUT        = 65535,
    parameter bit COL_ACTIVE_LOW = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_COLS-1:0]          matrix_col,
    input  logic [NUM_ROWS-1:0]          matrix_row,
    output logic [NUM_COLS*NUM_ROWS-1:0] frame,
    output logic                         frame_valid,
    output logic                         scan_error,
    output logic                         locked,
    output logic [7:0]                   error_count
);

    localparam logic [15:0] c_timeout  = 16'(TIMEOUT);
    localparam logic [2:0]  c_last_col = 3'(NUM_COLS - 1);

    logic                w_accept;
    logic [NUM_COLS-1:0] w_col;
    logic [NUM_ROWS-1:0] w_row;
    logic [2:0]          w_ones;
    logic [2:0]          w_idx;
    logic                w_one_hot;
    logic                w_multi;
    logic                w_err;

    logic [0:0]                   state_q, state_d;
    logic [2:0]                   expected_q, expected_d;
    logic [NUM_ROWS-1:0]          shadow_q [NUM_COLS];
    logic [NUM_ROWS-1:0]          shadow_d [NUM_COLS];
    logic [NUM_COLS*NUM_ROWS-1:0] frame_q, frame_d;
    logic                         frame_valid_q, frame_valid_d;
    logic                         scan_error_q, scan_error_d;
    logic                         locked_q, locked_d;
    logic [7:0]                   error_count_q, error_count_d;
    logic [15:0]                  tmo_q, tmo_d;

    matrix_scan_sync_filter #(
        .SETTLE         (SETTLE),
        .COL_ACTIVE_LOW (COL_ACTIVE_LOW)
    ) u_sync_filter (
        .clock    (clock),
        .reset    (reset),
        .i_col    (matrix_col),
        .i_row    (matrix_row),
        .o_accept (w_accept),
        .o_col    (w_col),
        .o_row    (w_row)
    );

    always_comb begin
        w_ones        = count_ones(w_col);
        w_idx         = col_index(w_col);
        w_one_hot     = w_accept && (w_ones == 3'd1);
        w_multi       = w_accept && (w_ones >= 3'd2);
        w_err         = 1'b0;
        state_d       = state_q;
        expected_d    = expected_q;
        shadow_d      = shadow_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        locked_d      = locked_q;
        error_count_d = error_count_q;
        tmo_d         = '0;

        case (state_q)
            ST_HUNT: begin
                if (w_multi) begin
                    w_err = 1'b1;
                end else if (w_one_hot && (w_idx == 3'd0)) begin
                    shadow_d[0] = w_row;
                    expected_d  = 3'd1;
                    state_d     = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // Multi-hot wins over a coincident timeout so only one error is raised.
                if (w_multi) begin
                    w_err      = 1'b1;
                    state_d    = ST_HUNT;
                    expected_d = 3'd0;
                end else if (w_one_hot) begin
                    if (w_idx == expected_q) begin
                        shadow_d[w_idx] = w_row;
                        if (w_idx == c_last_col) begin
                            for (int i = 0; i < NUM_COLS - 1; i++) begin
                                frame_d[i*NUM_ROWS +: NUM_ROWS] = shadow_q[i];
                            end
                            frame_d[(NUM_COLS-1)*NUM_ROWS +: NUM_ROWS] = w_row;
                            frame_valid_d = 1'b1;
                            locked_d      = 1'b1;
                            expected_d    = 3'd0;
                        end else begin
                            expected_d = expected_q + 3'd1;
                        end
                    end else begin
                        w_err      = 1'b1;
                        state_d    = ST_HUNT;
                        expected_d = 3'd0;
                        if (w_idx == 3'd0) begin
                            shadow_d[0] = w_row;
                            expected_d  = 3'd1;
                            state_d     = ST_CAPTURE;
                        end
                    end
                end else begin
                    tmo_d = tmo_q + 16'd1;
                    if (tmo_d == c_timeout) begin
                        w_err      = 1'b1;
                        state_d    = ST_HUNT;
                        expected_d = 3'd0;
                        tmo_d      = '0;
                    end
                end
            end
            default: begin
                state_d    = ST_HUNT;
                expected_d = 3'd0;
            end
        endcase

        scan_error_d = w_err;
        if (w_err) begin
            locked_d = 1'b0;
            if (error_count_q != 8'hFF) begin
                error_count_d = error_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_HUNT;
            expected_q    <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            scan_error_q  <= 1'b0;
            locked_q      <= 1'b0;
            error_count_q <= '0;
            tmo_q         <= '0;
            for (int i = 0; i < NUM_COLS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            expected_q    <= expected_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            scan_error_q  <= scan_error_d;
            locked_q      <= locked_d;
            error_count_q <= error_count_d;
            tmo_q         <= tmo_d;
            for (int i = 0; i < NUM_COLS; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign scan_error  = scan_error_q;
    assign locked      = locked_q;
    assign error_count = error_count_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_matrix_scan_receiver                                               |
// | Randomized scan stimulus checked through a scoreboard against a       |
// | dwell-level reference model.                                          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_matrix_scan_receiver;
    import matrix_scan_receiver_pkg::*;

    localparam int SETTLE  = 3;
    localparam int TIMEOUT = 100;
    localparam int LAT     = SETTLE + 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  matrix_col = 5'h1F;
    logic [6:0]  matrix_row = 7'h00;
    logic [34:0] frame;
    logic        frame_valid, scan_error, locked;
    logic [7:0]  error_count;

    matrix_scan_receiver #(
        .SETTLE         (SETTLE),
        .TIMEOUT        (TIMEOUT),
        .COL_ACTIVE_LOW (1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .matrix_col  (matrix_col),
        .matrix_row  (matrix_row),
        .frame       (frame),
        .frame_valid (frame_valid),
        .scan_error  (scan_error),
        .locked      (locked),
        .error_count (error_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit          is_frame;
        int          at;
        logic [34:0] frm;
        logic        lck;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: one step per constant-vector dwell on the pins.
    bit          m_cap;
    int          m_exp;
    logic [6:0]  m_sh [5];
    logic [34:0] m_frame;
    int          m_errs;
    int          m_last;
    logic [4:0]  last_vec;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        m_cap = 0; m_exp = 0; m_frame = '0; m_errs = 0; m_last = 0;
        for (int i = 0; i < 5; i++) m_sh[i] = '0;
        sb.delete();
    endtask

    task automatic push_err(input int at);
        exp_t e;
        m_errs = (m_errs < 255) ? m_errs + 1 : 255;
        m_cap  = 0;
        e.is_frame = 0; e.at = at; e.frm = m_frame; e.lck = 1'b0; e.cnt = 8'(m_errs);
        sb.push_back(e);
    endtask

    task automatic push_frame(input int at);
        exp_t e;
        for (int i = 0; i < 5; i++) m_frame[7*i +: 7] = m_sh[i];
        e.is_frame = 1; e.at = at; e.frm = m_frame; e.lck = 1'b1; e.cnt = 8'(m_errs);
        sb.push_back(e);
    endtask

    // A dwell of d cycles starting at cycle s is accepted iff d >= SETTLE; its
    // effect becomes visible LAT cycles after it first appears on the pins.
    task automatic model_dwell(input logic [4:0] vec, input logic [6:0] row, input int s, input int d);
        int p, n, c;
        p = s + LAT;
        n = $countones(vec);
        c = 0;
        for (int i = 0; i < 5; i++) if (vec[i]) c = i;
        if (d >= SETTLE) begin
            if (m_cap && p > m_last + TIMEOUT) push_err(m_last + TIMEOUT);
            if (n >= 2) begin
                push_err(p);
            end else if (n == 1) begin
                if (!m_cap) begin
                    if (c == 0) begin m_sh[0] = row; m_exp = 1; m_cap = 1; m_last = p; end
                end else begin
                    m_last = p;
                    if (c == m_exp) begin
                        m_sh[c] = row;
                        if (c == 4) begin push_frame(p); m_exp = 0; end
                        else m_exp = m_exp + 1;
                    end else begin
                        push_err(p);
                        if (c == 0) begin m_sh[0] = row; m_exp = 1; m_cap = 1; end
                    end
                end
            end
        end
        if (m_cap && m_last + TIMEOUT < s + d + LAT) push_err(m_last + TIMEOUT);
    endtask

    task automatic seg_raw(input logic [4:0] vec, input logic [6:0] row, input int d);
        model_dwell(vec, row, cyc, d);
        matrix_col = ~vec;
        matrix_row = row;
        last_vec   = vec;
        repeat (d) @(posedge clock);
        #1;
    endtask

    // Identical consecutive column dwells are split by a one-cycle blank.
    task automatic seg(input logic [4:0] vec, input logic [6:0] row, input int d);
        if (vec != 5'd0 && vec == last_vec) seg_raw(5'd0, 7'd0, 1);
        seg_raw(vec, row, d);
    endtask

    task automatic scan(input logic [6:0] r0, r1, r2, r3, r4, input int d);
        seg(5'b00001, r0, d); seg(5'b00010, r1, d); seg(5'b00100, r2, d);
        seg(5'b01000, r3, d); seg(5'b10000, r4, d);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_frame"}, frame, 35'd0);
        check({tag, "_frame_valid"}, frame_valid, 1'b0);
        check({tag, "_scan_error"}, scan_error, 1'b0);
        check({tag, "_locked"}, locked, 1'b0);
        check({tag, "_error_count"}, error_count, 8'd0);
    endtask

    task automatic reset_dut();
        matrix_col = 5'h1F;
        last_vec   = 5'd0;
        reset      = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_idle_outputs("in_reset");
        reset = 1'b0;
        model_reset();
        repeat (6) @(posedge clock);
        #1;
        check_idle_outputs("after_reset");
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && (frame_valid || scan_error)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: frame_valid=%0b scan_error=%0b required none (cycle %0d)",
                             frame_valid, scan_error, cyc);
                end else begin
                    e = sb.pop_front();
                    check("event_is_frame", frame_valid, e.is_frame);
                    check("event_is_error", scan_error, !e.is_frame);
                    check("event_cycle", cyc, e.at);
                    check("frame", frame, e.frm);
                    check("locked", locked, e.lck);
                    check("error_count", error_count, e.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        logic [4:0] v;
        model_reset();
        reset_dut();

        // Clean scan, 8-cycle dwells, one distinct bit per column.
        scan(7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 8);
        seg(5'd0, 7'd0, 8);
        check("clean_scan_locked", locked, 1'b1);
        check("clean_scan_frame", frame, 35'h1_0101_0101);

        // Skipped column 2.
        seg(5'b00001, 7'h11, 8); seg(5'b00010, 7'h22, 8); seg(5'b01000, 7'h33, 8);
        seg(5'd0, 7'd0, 10);
        check("skip_locked", locked, 1'b0);
        check("skip_frame_held", frame, 35'h1_0101_0101);

        // Two columns selected at once (pins 5'b11100).
        seg(5'b00011, 7'h00, 4);
        seg(5'd0, 7'd0, 10);

        // Blank gaps of 4 cycles with 2-cycle glitches inside them.
        for (int c = 0; c < 5; c++) begin
            seg(5'(1 << c), 7'($urandom), 6);
            seg(5'd0, 7'd0, 4);
            seg(5'(1 << ((c + 2) % 5)), 7'($urandom), 2);
            seg(5'd0, 7'd0, 4);
        end

        // Scan stalls after column 2, then recovers.
        seg(5'b00001, 7'h05, 6); seg(5'b00010, 7'h06, 6); seg(5'b00100, 7'h07, 6);
        seg(5'd0, 7'd0, 130);
        check("timeout_locked", locked, 1'b0);
        scan(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 5);

        // Randomized scanning with noise, skips, multi-hot and stalls.
        for (int f = 0; f < 25; f++) begin
            for (int c = 0; c < 5; c++) begin
                int col;
                col = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : c;
                seg(5'(1 << col), 7'($urandom), int'($urandom_range(SETTLE, 10)));
                if ($urandom_range(0, 2) == 0) begin
                    seg(5'd0, 7'($urandom), int'($urandom_range(1, 6)));
                    if ($urandom_range(0, 2) == 0) begin
                        seg(5'(1 << $urandom_range(0, 4)), 7'($urandom), int'($urandom_range(1, SETTLE - 1)));
                        seg(5'd0, 7'($urandom), int'($urandom_range(1, 4)));
                    end
                end
                if ($urandom_range(0, 39) == 0) seg(5'b10100, 7'($urandom), SETTLE);
                if ($urandom_range(0, 49) == 0) seg(5'd0, 7'd0, 120);
            end
        end
        seg(5'd0, 7'd0, 150);

        // Reset in the middle of column 3, then a fresh scan.
        scan(7'h0A, 7'h0B, 7'h0C, 7'h0D, 7'h0E, 6);
        seg(5'd0, 7'd0, 8);
        seg(5'b00001, 7'h41, 6); seg(5'b00010, 7'h42, 6); seg(5'b00100, 7'h43, 6);
        seg(5'b01000, 7'h44, 2);
        reset_dut();
        scan(7'h7F, 7'h55, 7'h2A, 7'h00, 7'h63, 6);
        seg(5'd0, 7'd0, 8);
        check("post_reset_locked", locked, 1'b1);

        // Error counter saturation.
        for (int k = 0; k < 300; k++) begin
            v = (k % 2 == 0) ? 5'b00110 : 5'b00011;
            seg(v, 7'd0, SETTLE);
        end
        seg(5'd0, 7'd0, 20);
        check("error_count_saturated", error_count, 8'd255);
        check("saturated_locked", locked, 1'b0);

        repeat (20) @(posedge clock);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
